// File: rtl/pll_seq_pkg.sv
// Shared types and 27 MHz timing defaults for the PLL reset sequencer.
// Includes a saturating increment for the 4-bit status counters.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 27000;
  localparam int unsigned DEF_STABLE_CYCLES = 2700;
  localparam int unsigned DEF_TMR_W         = 16;

  function automatic logic [3:0] sat_inc4(
    input logic [3:0] v
  );
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser with asynchronous active-low clear.
// Output lags the input by two clk edges.
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the async input through the two stages
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  // Synchroniser flops, cleared on rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives rPLL RESET, qualifies LOCK, and releases sys_rst_n after
// lock has been stable; retries on timeout or loss with debug counters.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned TMR_W         = DEF_TMR_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       soft_req,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic [1:0] state_o,
  output logic [3:0] retry_cnt,
  output logic [3:0] loss_cnt
);

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              pll_reset_q, pll_reset_d;
  logic              sys_rst_n_q, sys_rst_n_d;
  logic [3:0]        retry_q, retry_d;
  logic [3:0]        loss_q, loss_d;
  logic              retry_inc, loss_inc;
  logic              lock_s;

  pll_lock_sync u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      timer_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      retry_q     <= 4'd0;
      loss_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
    end
  end

  // Next state: soft_req, then lock events, then timer expiry
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    unique case (state_q)
      PLL_RST: begin
        if (timer_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (soft_req) begin
          state_d = PLL_RST;
        end else if (lock_s) begin
          state_d = STABLE;
        end else if (timer_q == TO_LAST) begin
          state_d   = PLL_RST;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (soft_req) begin
          state_d = PLL_RST;
        end else if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (timer_q == STB_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (soft_req) begin
          state_d = PLL_RST;
        end else if (!lock_s) begin
          state_d  = PLL_RST;
          loss_inc = 1'b1;
        end
      end
      default: state_d = PLL_RST;
    endcase
  end

  // Timer, outputs from next state, and saturating counters
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q != TMR_MAX) begin
      timer_d = timer_q + 1'b1;
    end
    pll_reset_d = (state_d == PLL_RST);
    sys_rst_n_d = (state_d == RUN);
    retry_d     = retry_inc ? sat_inc4(retry_q) : retry_q;
    loss_d      = loss_inc ? sat_inc4(loss_q) : loss_q;
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign state_o   = state_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controls the 27 MHz→72 MHz system rPLL: drives its RESET, watches its LOCK output, and releases the system reset only after lock has been stable for a set time.
- Retries automatically on lock timeout or lock loss, and keeps saturating status counters for debug LEDs/OSD.
- Runs on the free-running 27 MHz board clock, never on the PLL output.
- Re-synchronising sys_rst_n into the 72 MHz domain is done downstream, not here.

Parameters:
- RST_CYCLES, 16: cycles pll_reset is held high per reset pulse (≥1).
- LOCK_TIMEOUT, 27000: cycles allowed in WAIT_LOCK before a retry (1 ms at 27 MHz).
- STABLE_CYCLES, 2700: cycles lock must stay continuously high before release (100 µs).
- TMR_W, 16: timer width; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)-1.

Ports:
- clk  in  1  27 MHz board reference clock.
- rst_n  in  1  asynchronous active-low reset.
- pll_lock  in  1  rPLL LOCK; asynchronous to clk.
- soft_req  in  1  synchronous request to re-lock the PLL; level or pulse.
- pll_reset  out  1  to rPLL RESET, active high.
- sys_rst_n  out  1  system reset, active low; high only in RUN.
- state_o  out  2  current state encoding.
- retry_cnt  out  4  lock timeouts, saturating at 15.
- loss_cnt  out  4  lock losses while in RUN, saturating at 15.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low, on rst_n. All flops clear asynchronously on rst_n low.
- Reset values: state=PLL_RST, timer=0, pll_reset=1, sys_rst_n=0, retry_cnt=0, loss_cnt=0, sync flops=0.
- pll_lock passes through a 2-flop synchroniser to give lock_s (2-cycle latency). All decisions use lock_s only.
- Timer clears on every state transition, increments each cycle while the state holds, and never wraps inside any state.
- States: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3.
- PLL_RST: when timer==RST_CYCLES-1, go to WAIT_LOCK. soft_req is ignored here and the timer is not restarted.
- WAIT_LOCK:
  - If soft_req, go to PLL_RST.
  - Else if lock_s, go to STABLE.
  - Else if timer==LOCK_TIMEOUT-1, go to PLL_RST and increment retry_cnt (saturating).
- STABLE:
  - If soft_req, go to PLL_RST.
  - Else if !lock_s, go to WAIT_LOCK. No counter changes; the lock timeout restarts.
  - Else if timer==STABLE_CYCLES-1, go to RUN.
- RUN:
  - If soft_req, go to PLL_RST. No counter change.
  - Else if !lock_s, go to PLL_RST and increment loss_cnt (saturating).
- Priority: soft_req beats lock events, which beat the timer expiry.
- pll_reset and sys_rst_n are registered from next-state, so they change on the same edge as state_o:
  - pll_reset = (next==PLL_RST).
  - sys_rst_n = (next==RUN).
- Cycle counts:
  - pll_reset is high for exactly RST_CYCLES cycles per pulse.
  - sys_rst_n rises exactly STABLE_CYCLES cycles after entering STABLE.
  - sys_rst_n falls 3 edges after pll_lock falls: 2 for sync, 1 for transition.
- Saturated counters hold at 15 until rst_n. No glitches on outputs; all are flop outputs.
- rst_n asserted mid-operation returns everything to reset values immediately. After release the sequence restarts with a full RST_CYCLES pulse.

Decomposition:
- Shared package pll_seq_pkg:
  - state enum (PLL_RST/WAIT_LOCK/STABLE/RUN, 2 bits).
  - default timing constants for 27 MHz.
  - a saturating-increment function for 4-bit counters.
- One sub-module, pll_lock_sync: generic 2-flop synchroniser with async active-low clear. It is reused later for the downstream sys_rst_n re-sync.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8.
- Clean bring-up: release rst_n, raise pll_lock 10 cycles later and hold it. Expect pll_reset high for 4 cycles, state 0→1→2→3, sys_rst_n rising 8 cycles after STABLE entry, retry_cnt=0, loss_cnt=0.
- Lock timeout: hold pll_lock low. Expect a PLL_RST pulse every 24 cycles (4+20); retry_cnt counts 1,2,…, saturates at 15 after 15 timeouts, and stays at 15.
- Lock glitch in STABLE: lock high, then a 1-cycle drop after 5 cycles in STABLE. Expect return to WAIT_LOCK, then a fresh 8-cycle stable count before RUN; no counter change.
- Loss in RUN: drop pll_lock while in RUN. Expect sys_rst_n low 3 edges later, pll_reset high 4 cycles, loss_cnt=1, then normal re-lock to RUN.
- soft_req: pulse in RUN, expect PLL_RST with counters unchanged. Pulse during PLL_RST, expect it ignored and the pulse still exactly 4 cycles.
- Async reset mid-STABLE: assert rst_n low between clock edges. Expect immediate pll_reset=1, sys_rst_n=0, counters 0, and a full 4-cycle pulse after release.
